// File: rtl/nibble_word_packer_if.sv
// Nibble-in / word-out handshake bundle for nibble_word_packer.
// The slave side is the packer; the master side is whoever drives nibbles and drains words.
interface nibble_word_packer_if;
  logic [3:0]  d;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] word;
  logic        word_valid;
  logic        word_ready;
  logic [3:0]  word_idx;
  logic        word_last;

  modport master (
    output d, d_valid, word_ready,
    input  d_ready, word, word_valid, word_idx, word_last
  );

  modport slave (
    input  d, d_valid, word_ready,
    output d_ready, word, word_valid, word_idx, word_last
  );
endinterface

// File: rtl/nibble_word_packer.sv
// Packs a 4-bit nibble stream MSB-first into 32-bit words, tagged with their index inside a
// 16-word (512-bit) message block, behind a single-entry valid/ready output register.
module nibble_word_packer (
  input  logic                       clk,
  input  logic                       reset,
  nibble_word_packer_if.slave        bus
);

  logic [27:0] acc_q, acc_d;
  logic [2:0]  nib_cnt_q, nib_cnt_d;
  logic [31:0] word_q, word_d;
  logic        word_valid_q, word_valid_d;
  logic [3:0]  word_idx_q, word_idx_d;
  logic [3:0]  blk_cnt_q, blk_cnt_d;

  logic d_ready;
  logic accept;
  logic load;
  logic drain;

  // Only the word-completing nibble can be blocked, and only by a held word that is not draining.
  assign d_ready = !((nib_cnt_q == 3'd7) && word_valid_q && !bus.word_ready);
  assign accept  = bus.d_valid && d_ready;
  assign load    = accept && (nib_cnt_q == 3'd7);
  assign drain   = word_valid_q && bus.word_ready;

  always_comb begin
    acc_d        = acc_q;
    nib_cnt_d    = nib_cnt_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    word_idx_d   = word_idx_q;
    blk_cnt_d    = blk_cnt_q;

    if (drain) begin
      word_valid_d = 1'b0;
    end

    // A load on the draining edge overrides the clear above, so there is no bubble.
    if (load) begin
      word_d       = {acc_q, bus.d};
      word_idx_d   = blk_cnt_q;
      word_valid_d = 1'b1;
      blk_cnt_d    = blk_cnt_q + 4'd1;
      nib_cnt_d    = 3'd0;
      acc_d        = 28'd0;
    end else if (accept) begin
      acc_d     = {acc_q[23:0], bus.d};
      nib_cnt_d = nib_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q        <= 28'd0;
      nib_cnt_q    <= 3'd0;
      word_q       <= 32'd0;
      word_valid_q <= 1'b0;
      word_idx_q   <= 4'd0;
      blk_cnt_q    <= 4'd0;
    end else begin
      acc_q        <= acc_d;
      nib_cnt_q    <= nib_cnt_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      word_idx_q   <= word_idx_d;
      blk_cnt_q    <= blk_cnt_d;
    end
  end

  assign bus.d_ready    = d_ready;
  assign bus.word       = word_q;
  assign bus.word_valid = word_valid_q;
  assign bus.word_idx   = word_idx_q;
  assign bus.word_last  = word_valid_q && (word_idx_q == 4'hF);

endmodule

// File: tb/tb_nibble_word_packer.sv
// Scoreboard bench for nibble_word_packer: a nibble-list reference model pushes expected words,
// a separate monitor pops and compares them whenever the packer presents a word.
module tb_nibble_word_packer;

  logic clk;
  logic reset;
  nibble_word_packer_if bus ();

  nibble_word_packer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: accepted nibbles of the current word, one-deep output, block position.
  int          m_nibs[$];
  bit          m_full;
  int          m_blk;
  logic [35:0] sb[$];  // {idx, word}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_nibs.delete();
    m_full = 1'b0;
    m_blk  = 0;
    sb.delete();
  endtask

  // Called at posedge+1; drives one cycle and returns at the next posedge+1.
  task automatic step(input logic [3:0] nib, input logic dv, input logic wr, output logic acc);
    logic        exp_rdy;
    logic [31:0] w;
    bus.d          = nib;
    bus.d_valid    = dv;
    bus.word_ready = wr;
    #1;
    exp_rdy = !(m_nibs.size() == 7 && m_full && !wr);
    check("d_ready", {31'd0, bus.d_ready}, {31'd0, exp_rdy});
    check("word_valid", {31'd0, bus.word_valid}, {31'd0, m_full});
    acc = dv && exp_rdy;
    if (wr && m_full) m_full = 1'b0;
    if (acc) begin
      m_nibs.push_back(int'(nib));
      if (m_nibs.size() == 8) begin
        w = 32'd0;
        for (int i = 0; i < 8; i++) w = w * 16 + 32'(m_nibs[i]);
        sb.push_back({4'(m_blk), w});
        m_blk  = (m_blk + 1) % 16;
        m_nibs.delete();
        m_full = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] nib, input logic wr);
    logic a;
    int   n;
    a = 1'b0;
    n = 0;
    while (!a && n < 20) begin
      step(nib, 1'b1, wr, a);
      n++;
    end
    if (!a) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    bus.d_valid    = 1'b0;
    bus.word_ready = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("rst_word", bus.word, 32'd0);
    check("rst_valid", {31'd0, bus.word_valid}, 32'd0);
    check("rst_idx", {28'd0, bus.word_idx}, 32'd0);
    check("rst_last", {31'd0, bus.word_last}, 32'd0);
    model_clear();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(4'h0, 1'b0, 1'b1, a);
  endtask

  initial begin
    logic        a;
    logic        hold;
    logic [3:0]  nib;
    logic        dv;
    logic        wr;
    logic [35:0] e;

    reset          = 1'b0;
    bus.d          = 4'h0;
    bus.d_valid    = 1'b0;
    bus.word_ready = 1'b0;
    model_clear();

    fork
      forever begin
        @(negedge clk);
        if (reset) begin
          if (bus.word_valid) begin
            if (sb.size() == 0) begin
              check("unexpected_word", bus.word, 32'hxxxxxxxx);
            end else begin
              e = sb[0];
              check("word", bus.word, e[31:0]);
              check("word_idx", {28'd0, bus.word_idx}, {28'd0, e[35:32]});
              check("word_last", {31'd0, bus.word_last}, {31'd0, (e[35:32] == 4'hF)});
              if (bus.word_ready) void'(sb.pop_front());
            end
          end else begin
            check("last_idle", {31'd0, bus.word_last}, 32'd0);
          end
        end
      end
    join_none

    @(posedge clk);
    #1;
    do_reset();

    // Back-to-back stream
    for (int i = 1; i <= 8; i++) send(4'(i), 1'b1);
    check("b2b_word", bus.word, 32'h12345678);
    check("b2b_valid", {31'd0, bus.word_valid}, 32'd1);
    idle(2);

    // Backpressure: 1..F held against a stalled output, then 0 drains and loads together
    do_reset();
    for (int i = 1; i <= 15; i++) send(4'(i), 1'b0);
    check("bp_hold", bus.word, 32'h12345678);
    for (int i = 0; i < 3; i++) step(4'h0, 1'b1, 1'b0, a);
    step(4'h0, 1'b1, 1'b1, a);
    check("bp_next", bus.word, 32'h9ABCDEF0);
    check("bp_next_idx", {28'd0, bus.word_idx}, 32'd1);
    idle(2);

    // Gapped input
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(4'((10 + i) % 16), 1'b1);
      if (i < 7) begin
        step(4'($urandom), 1'b0, 1'b1, a);
        step(4'($urandom), 1'b0, 1'b1, a);
      end
    end
    check("gap_word", bus.word, 32'hABCDEF01);
    idle(2);

    // Block wrap: 17 words
    do_reset();
    for (int w = 0; w < 17; w++) begin
      for (int i = 0; i < 8; i++) send(4'($urandom), 1'b1);
      if (w == 15) check("wrap_last", {31'd0, bus.word_last}, 32'd1);
      if (w == 16) check("wrap_idx0", {28'd0, bus.word_idx}, 32'd0);
    end
    idle(2);

    // Reset mid-word
    do_reset();
    for (int i = 1; i <= 5; i++) send(4'(i), 1'b1);
    do_reset();
    for (int i = 9; i >= 2; i--) send(4'(i), 1'b1);
    check("mid_rst_word", bus.word, 32'h98765432);
    check("mid_rst_idx", {28'd0, bus.word_idx}, 32'd0);
    idle(2);

    // Random traffic with held nibbles and occasional resets
    hold = 1'b0;
    nib  = 4'h0;
    dv   = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        hold = 1'b0;
      end
      if (!hold) begin
        nib = 4'($urandom);
        dv  = ($urandom_range(0, 9) < 7);
      end
      wr = ($urandom_range(0, 9) < 6);
      step(nib, dv, wr, a);
      hold = dv && !a;
    end

    idle(3);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_word_packer.md
# nibble_word_packer

Downstream consumer of the 4-bit register stage: collects the registered 4-bit nibble stream into 32-bit words, MSB-nibble first, and hands them out on a valid/ready interface. It also tags each word with its position in a 512-bit (16-word) message block, for the SHA-256 message-schedule input. The block includes input backpressure and a single-entry output holding register, and passes a completed word through to that register in the same edge.

## Interface
- No parameters. Widths are fixed: 4-bit input, 32-bit word, 16 words per block.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low (0 = reset asserted); release is synchronous to clk upstream
- d  input  4  nibble from the 4-bit register stage
- d_valid  input  1  d carries a valid nibble this cycle
- d_ready  output  1  packer can accept a nibble this cycle
- word  output  32  packed word; first accepted nibble in [31:28]
- word_valid  output  1  word/word_idx/word_last valid
- word_ready  input  1  consumer accepts word this cycle
- word_idx  output  4  index of held word within its 16-word block
- word_last  output  1  high when word_idx == 15 and word_valid

## Operation
- Nibble accept: d_valid && d_ready at rising clk.
- Word handshake: word_valid && word_ready at rising clk.
- Internal state:
  - acc[27:0]: partial word.
  - nib_cnt[2:0]: nibbles held, 0..7.
  - Output register: word, word_valid, word_idx.
  - blk_cnt[3:0]: index for the next word loaded.
- Output register states:
  - EMPTY (word_valid=0) -> FULL on load.
  - FULL -> EMPTY on handshake without simultaneous load.
  - FULL -> FULL on handshake with simultaneous load.
- Accept with nib_cnt < 7:
  - acc <= {acc[23:0], d}
  - nib_cnt <= nib_cnt + 1
- Accept with nib_cnt == 7 (load):
  - word <= {acc[27:0], d}
  - word_idx <= blk_cnt
  - word_valid <= 1
  - blk_cnt <= blk_cnt + 1, wrapping 15 -> 0
  - nib_cnt <= 0
  - acc cleared
- d_ready = !(nib_cnt == 7 && word_valid && !word_ready). This is combinational from state and word_ready.
  - Nibbles 1..7 are always accepted, even while the output is stalled.
  - Nibble 8 is accepted if the output is EMPTY, or is FULL and draining in the same cycle.
- Simultaneous handshake and load: the new word replaces the old one; word_valid stays 1; no bubble.
- d_valid low: no state change in the packer; the output register drains independently.
- word_last = word_valid && (word_idx == 15). It is combinational from the registered word_idx.
- word, word_idx and word_last are stable while word_valid && !word_ready.
- d is ignored when d_valid=0, or when d_valid=1 and d_ready=0. Upstream must hold d until accepted.

## Timing
- Reset (reset=0, asynchronous, no clk edge needed):
  - Outputs: word=0, word_valid=0, word_idx=0, word_last=0; d_ready=1 once reset completes.
  - Internal: acc=0, nib_cnt=0, blk_cnt=0.
- Latency: word_valid rises on the same edge that accepts the 8th nibble, i.e. it is visible in the following cycle.
- Throughput: 1 nibble per cycle sustained with word_ready=1, giving one word every 8 cycles.
- Reset mid-word or mid-stall:
  - The partial word and the held word are discarded.
  - The block counter returns to 0.
  - The next accepted nibble starts word 0 of a new block.
- No flush: an incomplete word (fewer than 8 nibbles) is held indefinitely until it is completed.

## Test plan
- Reset: assert reset=0 mid-cycle with no clk edge -> word=0, word_valid=0, word_idx=0, word_last=0 immediately; d_ready=1 after release.
- Back-to-back stream: d=1,2,...,8 on consecutive cycles, d_valid=1, word_ready=1 -> word=0x12345678 with word_valid=1, word_idx=0 for exactly one cycle after the 8th nibble; d_ready never drops.
- Backpressure: word_ready=0 and 16 nibbles 1..F,0 offered continuously:
  - 0x12345678 is held stable.
  - Nibbles 9..F are accepted.
  - d_ready=0 while 0 is presented.
  - Then raise word_ready for one cycle -> 0x12345678 handshaken, nibble 0 accepted on the same edge, word=0x9ABCDEF0 (idx 1) valid next cycle with no bubble.
- Gapped input: d_valid toggled 1,0,0,1,... over nibbles A,B,C,D,E,F,0,1 -> word=0xABCDEF01 only after the 8th accepted nibble; idle cycles do not advance the count.
- Block wrap: 17 words streamed, word_ready=1 -> word_idx 0..15 then 0; word_last=1 only on the 16th word.
- Reset mid-word: 5 nibbles 1..5 accepted, then reset pulse, then nibbles 9,8,7,6,5,4,3,2 -> word=0x98765432, word_idx=0; the discarded nibbles never appear on word.
